// File: rtl/alu_operand_seq_pkg.sv
// rtl/alu_operand_seq_pkg.sv - shared FSM state and ALU opcode encodings
package alu_operand_seq_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_operand_seq_btn_debounce.sv
// rtl/alu_operand_seq_btn_debounce.sv - 2-flop sync, stability counter and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      // Any return to the accepted level restarts the stability window.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/alu_operand_seq.sv
// rtl/alu_operand_seq.sv - switch/button operand entry sequencer feeding a combinational ALU
module alu_operand_seq
  import alu_operand_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_next,
  input  logic              btn_clr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   ctrl,
  output logic              valid,
  input  logic [DATA_W-1:0] res_in,
  input  logic              car_in,
  input  logic              of_in,
  output logic [DATA_W-1:0] res_q,
  output logic              car_q,
  output logic              of_q,
  output logic [2:0]        state
);

  seq_state_t cur;
  seq_state_t nxt;
  logic       press;
  logic       clr_s1;
  logic       clr_s2;
  logic       ld_a;
  logic       ld_b;
  logic       ld_op;
  logic       ld_res;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_next),
    .press(press)
  );

  // Clear is level-sensitive and idempotent, so it only needs synchronizing.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      clr_s1 <= btn_clr;
      clr_s2 <= clr_s1;
    end
  end

  always_comb begin
    nxt    = cur;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_op  = 1'b0;
    ld_res = 1'b0;
    unique case (cur)
      S_A:    if (press) begin ld_a  = 1'b1; nxt = S_B;    end
      S_B:    if (press) begin ld_b  = 1'b1; nxt = S_OP;   end
      S_OP:   if (press) begin ld_op = 1'b1; nxt = S_EXEC; end
      S_EXEC: begin ld_res = 1'b1; nxt = S_SHOW; end
      S_SHOW: if (press) nxt = S_A;
      default: nxt = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_s2) begin
      cur   <= S_A;
      a     <= '0;
      b     <= '0;
      ctrl  <= '0;
      res_q <= '0;
      car_q <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (ld_a)  a    <= sw;
      if (ld_b)  b    <= sw;
      if (ld_op) ctrl <= sw[OP_W-1:0];
      if (ld_res) begin
        res_q <= res_in;
        car_q <= car_in;
        of_q  <= of_in;
      end
    end
  end

  assign valid = (cur == S_EXEC);
  assign state = cur;

endmodule

// File: tb/tb_alu_operand_seq.sv
// tb/tb_alu_operand_seq.sv - directed self-checking bench for alu_operand_seq
module tb_alu_operand_seq;
  import alu_operand_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] ctrl;
  logic       valid;
  logic [3:0] res_in;
  logic       car_in;
  logic       of_in;
  logic [3:0] res_q;
  logic       car_q;
  logic       of_q;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  logic [3:0] va;
  logic [3:0] vb;
  logic [2:0] vctrl;
  logic       ok;
  logic [2:0] s0;

  always #5 clk = ~clk;

  alu_operand_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .a(a), .b(b), .ctrl(ctrl), .valid(valid),
    .res_in(res_in), .car_in(car_in), .of_in(of_in),
    .res_q(res_q), .car_q(car_q), .of_q(of_q), .state(state)
  );

  // Stand-in for the board ALU: add/sub with carry and signed overflow.
  always_comb begin
    res_in = 4'd0;
    car_in = 1'b0;
    of_in  = 1'b0;
    case (ctrl)
      3'b000: begin
        {car_in, res_in} = {1'b0, a} + {1'b0, b};
        of_in = (a[3] == b[3]) && (res_in[3] != a[3]);
      end
      3'b001: begin
        {car_in, res_in} = {1'b0, a} + {1'b0, ~b} + 5'd1;
        of_in = (a[3] != b[3]) && (res_in[3] != a[3]);
      end
      default: res_in = a & b;
    endcase
  end

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt  <= vcnt + 1;
      va    <= a;
      vb    <= b;
      vctrl <= ctrl;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] v, input logic [3:0] after);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    sw = after;
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, {28'd0, a}, 32'd0);
    check({tag, "_b"}, {28'd0, b}, 32'd0);
    check({tag, "_ctrl"}, {29'd0, ctrl}, 32'd0);
    check({tag, "_res"}, {28'd0, res_q}, 32'd0);
    check({tag, "_flags"}, {30'd0, car_q, of_q}, 32'd0);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sw = 4'd0; btn_next = 1'b0; btn_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw = 4'($urandom); btn_next = 1'($urandom); btn_clr = 1'($urandom);
    end
    @(negedge clk);
    check_zero("rst");
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_vcnt", vcnt, 0);
    sw = 4'd0; btn_next = 1'b0; btn_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two 3-cycle bursts, both shorter than the debounce window.
    sw = 4'd3;
    btn_next = 1'b1; repeat (3) @(negedge clk);
    btn_next = 1'b0; repeat (2) @(negedge clk);
    btn_next = 1'b1; repeat (3) @(negedge clk);
    btn_next = 1'b0; repeat (12) @(negedge clk);
    check("bounce_state", {29'd0, state}, 32'd0);

    btn_next = 1'b1;
    repeat (200) @(negedge clk);
    check("hold_state", {29'd0, state}, 32'd1);
    check("hold_a", {28'd0, a}, 32'd3);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    press(4'd5, 4'd9);
    press(4'd0, 4'd6);
    check("add_vcnt", vcnt, 1);
    check("add_va", {28'd0, va}, 32'd3);
    check("add_vb", {28'd0, vb}, 32'd5);
    check("add_vctrl", {29'd0, vctrl}, 32'd0);
    check("add_res", {28'd0, res_q}, 32'd8);
    check("add_car", {31'd0, car_q}, 32'd0);
    check("add_of", {31'd0, of_q}, 32'd1);
    check("add_state", {29'd0, state}, 32'd4);

    // Transition must land exactly on edge k+6.
    @(negedge clk);
    btn_next = 1'b1;
    s0 = state;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (state !== s0) ok = 1'b0;
    end
    check("tm_hold", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    check("tm_adv", {29'd0, state}, 32'd0);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    press(4'd2, 4'd9);
    check("sub_a", {28'd0, a}, 32'd2);
    press(4'd7, 4'd0);
    press(4'd1, 4'd4);
    check("sub_b", {28'd0, b}, 32'd7);
    check("sub_ctrl", {29'd0, ctrl}, 32'd1);
    check("sub_res", {28'd0, res_q}, 32'hB);
    check("sub_car", {31'd0, car_q}, 32'd0);
    check("sub_state", {29'd0, state}, 32'd4);
    check("sub_vcnt", vcnt, 2);

    press(4'd0, 4'd0);
    press(4'd6, 4'd0);
    press(4'd4, 4'd0);
    check("pre_clr_state", {29'd0, state}, 32'd2);

    // Clear synchronizer output goes high in the same cycle as press.
    @(negedge clk);
    sw = 4'd5;
    btn_next = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_zero("clr");
    @(negedge clk);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
    check("clr_vcnt", vcnt, 2);

    btn_clr = 1'b1;
    repeat (2) @(negedge clk);
    btn_clr = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("clr2");

    press(4'd2, 4'd0);
    check("mid_pre_state", {29'd0, state}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    check("mid_rst_valid", {31'd0, valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_seq.md
# alu_operand_seq

Operand-entry sequencer that sits directly upstream of the 4-bit ALU on the board. It collects operand A, operand B and the 3-bit operation code one at a time from the 4 slide switches, advancing on each debounced press of a push-button. It then presents them to the ALU for one issue cycle and latches the ALU's result and flags for display. The ALU itself stays purely combinational; this block supplies all the sequencing around it.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button level change is accepted. Legal range 2..2^20. The board top overrides it to about 1_000_000.

Ports:
- `clk` input 1: single system clock
- `rst` input 1: synchronous, active-high reset
- `sw` input 4: raw slide switches (data entry)
- `btn_next` input 1: raw, bouncing, asynchronous push-button; advances the sequence
- `btn_clr` input 1: raw asynchronous clear request
- `a` output 4: operand A to ALU
- `b` output 4: operand B to ALU
- `ctrl` output 3: ALU operation code
- `valid` output 1: one-cycle issue strobe; a/b/ctrl are committed
- `res_in` input 4: ALU result
- `car_in` input 1: ALU carry
- `of_in` input 1: ALU overflow
- `res_q` output 4: latched result
- `car_q` output 1: latched carry
- `of_q` output 1: latched overflow
- `state` output 3: current FSM state, for LEDs

## Operation
- Input conditioning:
  - `btn_next` and `btn_clr` each pass through a 2-flop synchronizer (s1, s2).
  - `btn_next` is additionally debounced, each edge:
    - if s2 == level, then cnt <= 0;
    - else if cnt == DEBOUNCE_CYCLES-1, then level <= s2 and cnt <= 0;
    - else cnt <= cnt+1.
  - press = level & ~level_d, high exactly one cycle per accepted rising level. Releases produce no press.
  - `btn_clr` is synchronized only, not debounced. Clear is idempotent.
- FSM states (encoding on `state`): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A + press: a <= sw; go to S_B.
  - S_B + press: b <= sw; go to S_OP.
  - S_OP + press: ctrl <= sw[2:0]; go to S_EXEC.
  - S_EXEC: unconditional. valid=1. res_q/car_q/of_q <= res_in/car_in/of_in at the end of this cycle; go to S_SHOW.
  - S_SHOW + press: go to S_A. a, b and ctrl keep their old values until overwritten.
  - No press: hold state.
- Clear (synchronized s2 of `btn_clr` high): go to S_A; a, b, ctrl, res_q, car_q, of_q <= 0. Clear beats a simultaneous press, including in S_EXEC; no capture occurs.
- `sw` is sampled only on the press cycle. Later switch changes never alter a latched value.
- Holding `btn_next` indefinitely yields exactly one press.

## Timing
- Reset, applied on any edge (mid-sequence too): state=S_A; a=b=ctrl=0; res_q=0, car_q=of_q=0; valid=0; synchronizers, level, level_d and cnt all cleared.
- Let k be the first edge sampling `btn_next`=1, with the raw input held high thereafter:
  - s2 is high after edge k+1;
  - level rises at edge k+1+DEBOUNCE_CYCLES;
  - press is high in the following cycle;
  - the FSM transition occurs at edge k+2+DEBOUNCE_CYCLES.
- Any s2 high pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Clear latency: raw `btn_clr` sampled at edge k, so s2 is high after edge k+1 and the clear takes effect at edge k+2.
- `valid` is high for exactly one cycle per sequence, with a/b/ctrl stable throughout it. ALU results are captured at the same edge that ends `valid` (0-cycle ALU latency).
- Outputs a, b, ctrl, res_q, car_q, of_q and state are all registered. `valid` is decoded from state == S_EXEC.

## Structure
- Shared package: state encoding constants (S_A..S_SHOW) and the ALU opcode constants (ADD=000 … EQ=111), also used by the ALU and the board top.
- Sub-module `btn_debounce`: synchronizer, counter and level register, plus the one-cycle press output. Parameterized by DEBOUNCE_CYCLES and instantiated once for `btn_next`.

## Test plan
All tests use DEBOUNCE_CYCLES=4, with the ALU instantiated behind this block.
- Reset: hold rst 3 cycles with random inputs -> all outputs 0, state=0, valid never high.
- Full add sequence: press with sw=3, then sw=5, then sw=0 -> valid high one cycle with a=3, b=5, ctrl=000. Then res_q=8, car_q=0, of_q=1, state=4.
- Timing check: raw btn_next rises, first sampled at edge k -> state changes at edge k+6 exactly.
- Bounce: btn_next high 3 cycles, low 2, high 3, then low -> no state change. A steady hold of 200 cycles -> exactly one advance.
- Clear: in S_OP assert btn_clr in the same cycle press fires -> state=0; a, b, ctrl and res_q all 0. Clearing again in S_A leaves everything unchanged.
- Subtract and sampling: enter a=2, b=7, ctrl=001, changing sw right after each press -> latched a=2, b=7. Then res_q=4'hB, car_q=0. Mid-sequence rst in S_B -> full reset values.
